// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master system bus arbiter: state encoding,
// default bus widths and the slave address windows used by the decoder.
package bus_arbiter_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;
  localparam int NUM_M      = 2;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_e;

  // Slave windows (inclusive bounds), also consumed by the address decoder.
  localparam logic [15:0] S0_BASE = 16'h0000;
  localparam logic [15:0] S0_LAST = 16'h07FF;
  localparam logic [15:0] S1_BASE = 16'h7000;
  localparam logic [15:0] S1_LAST = 16'h71FF;

  function automatic arb_state_e gnt_state(input logic m);
    return m ? ARB_GNT1 : ARB_GNT0;
  endfunction

endpackage

// File: rtl/bus_mux2.sv
// Combinational owner mux: AND-OR select of request, write, address and data
// by a one-hot grant vector. Outputs are all-zero when nobody holds a grant.
module bus_mux2 #(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic [NUM_M-1:0]             grant,
  input  logic [NUM_M-1:0]             req,
  input  logic [NUM_M-1:0]             wr,
  input  logic [NUM_M-1:0][ADDR_W-1:0] addr,
  input  logic [NUM_M-1:0][DATA_W-1:0] data,
  output logic                         m_req,
  output logic                         s_wr,
  output logic [ADDR_W-1:0]            s_address,
  output logic [DATA_W-1:0]            s_din
);

  always_comb begin
    m_req     = 1'b0;
    s_wr      = 1'b0;
    s_address = '0;
    s_din     = '0;
    for (int i = 0; i < NUM_M; i++) begin
      m_req     |= grant[i] & req[i];
      s_wr      |= grant[i] & req[i] & wr[i];
      s_address |= addr[i] & {ADDR_W{grant[i]}};
      s_din     |= data[i] & {DATA_W{grant[i]}};
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with grant held while the owner requests.
// Define BUS_ARB_TIMEOUT_EN to force handover after TENURE_MAX granted cycles.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int TENURE_MAX = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [DATA_W-1:0] m0_dout,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [DATA_W-1:0] m1_dout,
  output logic              m0_grant,
  output logic              m1_grant,
  output logic              m_req,
  output logic              s_wr,
  output logic [ADDR_W-1:0] s_address,
  output logic [DATA_W-1:0] s_din
);

  localparam logic [7:0] TEN_SAT = 8'(TENURE_MAX - 1);

  arb_state_e       state_q, state_d;
  logic             last_q, last_d;
  logic [7:0]       ten_q, ten_d;
  logic [NUM_M-1:0] grant_q, grant_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        // On a tie the master that did not own the bus last time wins.
        if (m0_req && m1_req) state_d = gnt_state(!last_q);
        else if (m0_req)      state_d = ARB_GNT0;
        else if (m1_req)      state_d = ARB_GNT1;
      end
      ARB_GNT0: begin
`ifdef BUS_ARB_TIMEOUT_EN
        if (ten_q == TEN_SAT && m1_req) state_d = ARB_GNT1;
        else
`endif
        if (!m0_req) state_d = m1_req ? ARB_GNT1 : ARB_IDLE;
      end
      ARB_GNT1: begin
`ifdef BUS_ARB_TIMEOUT_EN
        if (ten_q == TEN_SAT && m0_req) state_d = ARB_GNT0;
        else
`endif
        if (!m1_req) state_d = m0_req ? ARB_GNT0 : ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    last_d = last_q;
    ten_d  = ten_q;
    if (state_d != state_q) begin
      ten_d = '0;
      if (state_d == ARB_GNT0) last_d = 1'b0;
      if (state_d == ARB_GNT1) last_d = 1'b1;
    end else if (state_q != ARB_IDLE && ten_q != TEN_SAT) begin
      ten_d = ten_q + 8'd1;
    end
    grant_d = {state_d == ARB_GNT1, state_d == ARB_GNT0};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
      last_q  <= 1'b1;
      ten_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      ten_q   <= ten_d;
      grant_q <= grant_d;
    end
  end

  assign m0_grant = grant_q[0];
  assign m1_grant = grant_q[1];

  bus_mux2 #(
    .NUM_M (NUM_M),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mux (
    .grant    (grant_q),
    .req      ({m1_req, m0_req}),
    .wr       ({m1_wr, m0_wr}),
    .addr     ({m1_address, m0_address}),
    .data     ({m1_dout, m0_dout}),
    .m_req    (m_req),
    .s_wr     (s_wr),
    .s_address(s_address),
    .s_din    (s_din)
  );

endmodule
